// File: rtl/suba_ctrl_pkg.sv
// Shared types and helpers for the subA round-robin controller.
package suba_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_e;

    localparam int DATA_W_DEF = 8;
    localparam int MAX_NREQ   = 8;
    localparam int MAX_IDX_W  = 3;

    // First requester at or after ptr (wrapping modulo nreq) with its request bit set.
    // The loop walks offsets from the far end back to zero so the nearest hit wins.
    function automatic logic [MAX_IDX_W-1:0] rr_pick(input logic [MAX_NREQ-1:0]  req,
                                                    input logic [MAX_IDX_W-1:0] ptr,
                                                    input int                   nreq);
        logic [MAX_IDX_W-1:0] pick;
        logic [MAX_IDX_W:0]   sum;
        pick = '0;
        for (int k = MAX_NREQ - 1; k >= 0; k--) begin
            if (k < nreq) begin
                sum = {1'b0, ptr} + (MAX_IDX_W + 1)'(k);
                if (sum >= (MAX_IDX_W + 1)'(nreq)) begin
                    sum = sum - (MAX_IDX_W + 1)'(nreq);
                end
                if (req[sum[MAX_IDX_W-1:0]]) begin
                    pick = sum[MAX_IDX_W-1:0];
                end
            end
        end
        return pick;
    endfunction

    // Pointer after serving grant: the requester just served drops to lowest priority.
    function automatic logic [MAX_IDX_W-1:0] rr_next(input logic [MAX_IDX_W-1:0] grant,
                                                    input int                   nreq);
        return (int'(grant) + 1 >= nreq) ? '0 : grant + MAX_IDX_W'(1);
    endfunction

endpackage

// File: rtl/suba_rr_arb.sv
// Combinational round-robin arbiter: request vector plus pointer to one-hot grant.
module suba_rr_arb
    import suba_ctrl_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_grant_oh,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic             o_any
);

    logic [MAX_NREQ-1:0]  w_req_ext;
    logic [MAX_IDX_W-1:0] w_pick;

    // Widen the request vector to the package maximum and pick the winner.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
        w_req_ext              = '0;
        w_req_ext[NREQ-1:0]    = i_req;
        w_pick                 = rr_pick(w_req_ext, MAX_IDX_W'(i_ptr), NREQ);
        o_any                  = |i_req;
        o_grant_idx            = IDX_W'(w_pick);
        o_grant_oh             = '0;
        if (o_any) begin
            o_grant_oh[o_grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/suba_rr_ctrl.sv
// Round-robin sequencer sharing one subA bit path between NREQ byte requesters.
// A granted byte is shifted MSB-first into subA; the returned bits are rebuilt
// and compared against the bitwise inverse of the byte that was sent.
module suba_rr_ctrl
    import suba_ctrl_pkg::*;
#(
    parameter  int NREQ   = 4,
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int CNT_W  = 8,
    localparam int ID_W   = $clog2(NREQ),
    localparam int BIT_W  = $clog2(DATA_W)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output logic [DATA_W-1:0]      resp_data,
    output logic                   resp_err,
    output logic                   suba_in_bit1,
    input  logic                   suba_out_bit1,
    output logic                   busy,
    output logic [CNT_W-1:0]       err_count
);

    state_e              r_state;
    state_e              w_next_state;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     r_grant;
    logic [DATA_W-1:0]   r_tx_shift;
    logic [DATA_W-1:0]   r_tx_byte;
    logic [DATA_W-1:0]   r_rx_shift;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic [CNT_W-1:0]    r_err_count;

    logic [NREQ-1:0]     w_grant_oh;
    logic [ID_W-1:0]     w_grant_idx;
    logic                w_any;
    logic                w_accept;
    logic                w_last_bit;
    logic                w_err;
    logic [DATA_W-1:0]   w_req_byte;

    suba_rr_arb #(
        .NREQ (NREQ)
    ) u_arb (
        .i_req       (req_valid),
        .i_ptr       (r_ptr),
        .o_grant_oh  (w_grant_oh),
        .o_grant_idx (w_grant_idx),
        .o_any       (w_any)
    );

    // A reset cycle never accepts, so no requester sees a ready it will not be served for.
    assign w_accept   = (r_state == IDLE) && w_any && !rst;
    assign w_last_bit = (r_bit_cnt == BIT_W'(DATA_W - 1));
    assign w_req_byte = req_data[w_grant_idx*DATA_W +: DATA_W];
    assign w_err      = (r_rx_shift != ~r_tx_byte);

    // Result fields only carry meaning while a response is being offered.
    assign resp_id    = (r_state == RESP) ? r_grant    : '0;
    assign resp_data  = (r_state == RESP) ? r_rx_shift : '0;
    assign resp_err   = (r_state == RESP) && w_err;
    assign busy       = (r_state != IDLE);
    assign err_count  = r_err_count;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and per-state outputs.
    always_comb begin
        w_next_state = r_state;
        req_ready    = w_accept ? w_grant_oh : '0;
        resp_valid   = 1'b0;
        suba_in_bit1 = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                suba_in_bit1 = r_tx_shift[DATA_W-1];
                if (w_last_bit) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath: latch the granted byte, shift bits through subA, settle the response.
    always_ff @(posedge clk) begin
        // NOTE: the shift and result registers are plain flops, not a memory, so they are reset to a known zero.
        if (rst) begin
            r_ptr       <= '0;
            r_grant     <= '0;
            r_tx_shift  <= '0;
            r_tx_byte   <= '0;
            r_rx_shift  <= '0;
            r_bit_cnt   <= '0;
            r_err_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_grant    <= w_grant_idx;
                        r_tx_shift <= w_req_byte;
                        r_tx_byte  <= w_req_byte;
                        r_rx_shift <= '0;
                        r_bit_cnt  <= '0;
                    end
                end
                SHIFT: begin
                    r_tx_shift <= r_tx_shift << 1;
                    r_rx_shift <= {r_rx_shift[DATA_W-2:0], suba_out_bit1};
                    r_bit_cnt  <= r_bit_cnt + BIT_W'(1);
                end
                RESP: begin
                    if (resp_ready) begin
                        r_ptr <= ID_W'(rr_next(MAX_IDX_W'(r_grant), NREQ));
                        if (w_err && (r_err_count != '1)) begin
                            r_err_count <= r_err_count + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_suba_rr_ctrl.sv
// Self-checking bench for suba_rr_ctrl: transaction-level reference model,
// scoreboard queue filled at accept and drained at the response handshake.
module tb_suba_rr_ctrl;

    localparam int NREQ   = 4;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;
    localparam int ID_W   = $clog2(NREQ);
    localparam int LAT    = DATA_W + 1;
    localparam int PERIOD = DATA_W + 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef enum int {M_INV, M_STUCK0, M_PASS} mode_e;

    typedef struct {
        int                id;
        logic [DATA_W-1:0] sent;
        logic [DATA_W-1:0] data;
        logic              err;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NREQ-1:0]        req_valid = '0;
    logic [NREQ*DATA_W-1:0] req_data = '0;
    logic [NREQ-1:0]        req_ready;
    logic                   resp_valid;
    logic                   resp_ready = 1'b0;
    logic [ID_W-1:0]        resp_id;
    logic [DATA_W-1:0]      resp_data;
    logic                   resp_err;
    logic                   suba_in_bit1;
    logic                   suba_out_bit1;
    logic                   busy;
    logic [CNT_W-1:0]       err_count;

    mode_e mode = M_INV;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Reference model state
    exp_t              sb[$];
    int                mp = 0;
    bit                model_busy = 1'b0;
    int                cur_acc = 0;
    logic [DATA_W-1:0] cur_sent = '0;
    int                model_errs = 0;
    int                n_resp = 0;

    // Observed DUT history used by directed checks
    logic [NREQ-1:0]   acc_mask = '0;
    int                dut_grants[$];
    int                acc_cycles[$];
    logic [DATA_W:0]   resp_log[$];
    int                dut_hs = 0;

    always #5 clk = ~clk;

    suba_rr_ctrl #(
        .NREQ   (NREQ),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_id       (resp_id),
        .resp_data     (resp_data),
        .resp_err      (resp_err),
        .suba_in_bit1  (suba_in_bit1),
        .suba_out_bit1 (suba_out_bit1),
        .busy          (busy),
        .err_count     (err_count)
    );

    // subA stand-in: healthy inverter, stuck-at-0 fault, or pass-through fault
    assign suba_out_bit1 = (mode == M_INV)    ? ~suba_in_bit1 :
                           (mode == M_STUCK0) ? 1'b0 : suba_in_bit1;

    function automatic logic [DATA_W-1:0] suba_expect(input mode_e m, input logic [DATA_W-1:0] s);
        case (m)
            M_INV:    return ~s;
            M_STUCK0: return '0;
            default:  return s;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: bound expired, required completion within budget (cycle %0d)", name, cyc);
    endtask

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    int                pred;
    int                k;
    logic [NREQ-1:0]   exp_ready;
    bit                in_resp;
    logic              exp_bit;
    exp_t              e;

    // Monitor: compare DUT outputs against the model, then advance the model
    always @(negedge clk) begin
        pred = -1;
        for (int j = 0; j < NREQ; j++) begin
            if (pred < 0 && ((req_valid >> ((mp + j) % NREQ)) & 1) != 0) pred = (mp + j) % NREQ;
        end
        exp_ready = '0;
        if (!model_busy && !rst && pred >= 0) exp_ready = NREQ'(1) << pred;
        k       = cyc - cur_acc;
        in_resp = model_busy && (k >= LAT);
        exp_bit = 1'b0;
        if (model_busy && k >= 1 && k <= DATA_W) exp_bit = 1'(cur_sent >> (DATA_W - k));

        check("req_ready",    64'(req_ready),    64'(exp_ready));
        check("busy",         64'(busy),         64'(model_busy));
        check("suba_in_bit1", 64'(suba_in_bit1), 64'(exp_bit));
        check("resp_valid",   64'(resp_valid),   64'(in_resp));
        check("err_count",    64'(err_count),    64'(model_errs));
        if (resp_valid && in_resp) begin
            if (sb.size() == 0) begin
                fail("scoreboard_empty");
            end else begin
                check("resp_id",   64'(resp_id),   64'(sb[0].id));
                check("resp_data", 64'(resp_data), 64'(sb[0].data));
                check("resp_err",  64'(resp_err),  64'(sb[0].err));
            end
        end

        acc_mask = req_ready;
        for (int j = 0; j < NREQ; j++) begin
            if (((req_ready >> j) & 1) != 0) begin
                dut_grants.push_back(j);
                acc_cycles.push_back(cyc);
            end
        end
        if (resp_valid && resp_ready && !rst) begin
            dut_hs++;
            resp_log.push_back({resp_err, resp_data});
        end

        if (rst) begin
            sb.delete();
            model_busy = 1'b0;
            mp         = 0;
            model_errs = 0;
        end else if (exp_ready != '0) begin
            e.id   = pred;
            e.sent = DATA_W'(req_data >> (pred * DATA_W));
            e.data = suba_expect(mode, e.sent);
            e.err  = (e.data != ~e.sent);
            sb.push_back(e);
            model_busy = 1'b1;
            cur_acc    = cyc;
            cur_sent   = e.sent;
            mp         = (pred + 1) % NREQ;
        end else if (in_resp && resp_ready && sb.size() > 0) begin
            e = sb.pop_front();
            if (e.err && model_errs < CNT_MAX) model_errs++;
            model_busy = 1'b0;
            n_resp++;
        end
    end

    // Driver helpers: requesters drop valid only once they have seen req_ready
    task automatic tick();
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc_mask;
    endtask

    task automatic raise(input int i, input logic [DATA_W-1:0] d);
        req_valid[i]                   = 1'b1;
        req_data[i*DATA_W +: DATA_W]   = d;
    endtask

    task automatic raise_idle_all();
        for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i]) raise(i, DATA_W'($urandom));
        end
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        for (int t = 0; t < budget; t++) begin
            if (req_valid == '0 && !model_busy) return;
            tick();
        end
        fail(name);
    endtask

    int b;
    int h;
    bit ok;

    // Stimulus sequence
    initial begin
        tick();

        // Single transfer through a healthy subA
        do_reset();
        mode = M_INV;
        resp_ready = 1'b1;
        b = dut_grants.size();
        h = resp_log.size();
        raise(0, 8'hA5);
        wait_idle(40, "single_transfer");
        if (dut_grants.size() > b) check("single_grant", 64'(dut_grants[b]), 64'(0));
        else fail("single_grant");
        if (resp_log.size() > h) check("single_resp", 64'(resp_log[h]), 64'({1'b0, 8'h5A}));
        else fail("single_resp");

        // All requesters continuously valid: strict rotation at full throughput
        do_reset();
        b = dut_grants.size();
        raise_idle_all();
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            tick();
            if (dut_grants.size() >= b + 5) begin
                ok = 1'b1;
                break;
            end
            raise_idle_all();
        end
        if (!ok) fail("rotation");
        wait_idle(100, "rotation_drain");
        for (int i = 0; i < 5; i++) begin
            if (dut_grants.size() > b + i) check("rotation_order", 64'(dut_grants[b + i]), 64'(i % NREQ));
        end
        for (int i = 0; i < 4; i++) begin
            if (acc_cycles.size() > b + i + 1)
                check("rotation_period", 64'(acc_cycles[b + i + 1] - acc_cycles[b + i]), 64'(PERIOD));
        end

        // Stuck-at-0 subA: inverse of 8'hFF matches, 8'h0F does not
        do_reset();
        mode = M_STUCK0;
        h = resp_log.size();
        raise(0, 8'hFF);
        wait_idle(40, "stuck_ff");
        raise(0, 8'h0F);
        wait_idle(40, "stuck_0f");
        if (resp_log.size() >= h + 2) begin
            check("stuck_ff_resp", 64'(resp_log[h]),     64'({1'b0, 8'h00}));
            check("stuck_0f_resp", 64'(resp_log[h + 1]), 64'({1'b1, 8'h00}));
        end else fail("stuck_resp_count");
        check("stuck_err_count", 64'(err_count), 64'(1));

        // Back-pressure: resp_ready low for 5 RESP cycles with another requester waiting
        do_reset();
        mode = M_INV;
        resp_ready = 1'b0;
        b = dut_grants.size();
        raise(0, 8'h3C);
        raise(1, 8'hC3);
        ok = 1'b0;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (model_busy && (cyc - cur_acc) >= LAT) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail("reach_resp");
        for (int t = 0; t < 5; t++) tick();
        resp_ready = 1'b1;
        wait_idle(60, "backpressure_drain");
        if (dut_grants.size() >= b + 2) begin
            check("bp_next_grant", 64'(dut_grants[b + 1]), 64'(1));
            check("bp_gap", 64'(acc_cycles[b + 1] - acc_cycles[b]), 64'(PERIOD + 5));
        end else fail("bp_grant_count");

        // Reset in the 4th SHIFT cycle aborts the transfer and clears the pointer
        do_reset();
        raise(2, 8'h81);
        wait_idle(40, "pre_abort");
        raise(3, 8'h42);
        ok = 1'b0;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (model_busy && cyc == cur_acc + 4) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail("abort_align");
        h = dut_hs;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_in_bit", 64'(suba_in_bit1), 64'(0));
        b = dut_grants.size();
        raise(3, 8'h42);
        raise(0, 8'h24);
        wait_idle(60, "post_abort");
        if (dut_grants.size() >= b + 2) begin
            check("post_abort_first", 64'(dut_grants[b]),     64'(0));
            check("post_abort_second", 64'(dut_grants[b + 1]), 64'(3));
        end else fail("post_abort_grants");
        check("abort_no_resp", 64'(dut_hs - h), 64'(2));

        // 300 errored transfers saturate the counter
        do_reset();
        mode = M_PASS;
        resp_ready = 1'b1;
        h = n_resp;
        raise_idle_all();
        ok = 1'b0;
        for (int t = 0; t < 300 * PERIOD + 200; t++) begin
            tick();
            if (n_resp >= h + 300) begin
                ok = 1'b1;
                break;
            end
            raise_idle_all();
        end
        if (!ok) fail("saturate_run");
        wait_idle(100, "saturate_drain");
        check("err_count_saturated", 64'(err_count), 64'(CNT_MAX));

        // Randomized traffic with random back-pressure
        for (int m = 0; m < 2; m++) begin
            do_reset();
            mode = (m == 0) ? M_INV : M_STUCK0;
            for (int t = 0; t < 600; t++) begin
                resp_ready = ($urandom_range(0, 3) != 0);
                for (int i = 0; i < NREQ; i++) begin
                    if (!req_valid[i] && $urandom_range(0, 3) == 0) raise(i, DATA_W'($urandom));
                end
                tick();
            end
            resp_ready = 1'b1;
            wait_idle(200, "random_drain");
        end

        check("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/suba_rr_ctrl.md
Name: suba_rr_ctrl

Overview:
Round-robin controller that shares one subA bit-path instance between NREQ byte requesters. It accepts a byte from the granted requester and serialises it MSB-first onto subA's in_bit1. It samples subA's out_bit1 each bit-cycle, rebuilds the returned byte, and reports the result plus an inversion-check error flag. It sits beside subA in the codecoverage sandbox as its sequencer and arbiter.

Parameters:
NREQ, 4, number of requesters (2..8)
DATA_W, 8, bits per transfer
CNT_W, 8, width of saturating error counter

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  NREQ  per-requester request valid
req_data  input  NREQ*DATA_W  per-requester byte; requester i occupies bits [i*DATA_W +: DATA_W]
req_ready  output  NREQ  one-hot accept pulse
resp_valid  output  1  result available
resp_ready  input  1  consumer accepts result
resp_id  output  $clog2(NREQ)  index of served requester
resp_data  output  DATA_W  byte reconstructed from out_bit1
resp_err  output  1  resp_data != ~sent byte
suba_in_bit1  output  1  drives subA in_bit1
suba_out_bit1  input  1  from subA out_bit1; combinational from in_bit1
busy  output  1  state != IDLE
err_count  output  CNT_W  saturating count of errored transfers

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: all outputs 0; state=IDLE; rr pointer=0; shift/result registers=0.
- A reset asserted mid-transfer aborts the transfer immediately. No response is produced and no req_ready is issued for the aborted transfer.
- States: IDLE, SHIFT, RESP.
- IDLE:
  - If any req_valid is high, grant the first requester at or after the rr pointer, wrapping modulo NREQ.
  - req_ready[grant]=1 for exactly this cycle (combinational from state, pointer and req_valid); this is the accept cycle.
  - Latch req_data slice and grant index; bit_cnt=0; next state SHIFT.
  - If no request is valid, stay in IDLE.
- SHIFT (exactly DATA_W cycles):
  - suba_in_bit1 = tx_shift[MSB].
  - Each cycle: sample suba_out_bit1 into rx_shift LSB, shifting left; shift tx_shift left; bit_cnt++.
  - After the cycle with bit_cnt==DATA_W-1, go to RESP.
  - suba_in_bit1 is 0 in every other state.
- RESP:
  - resp_valid=1; resp_id, resp_data and resp_err are held stable until resp_ready.
  - resp_err = (rx_shift != ~tx_byte_latched).
  - On resp_valid&&resp_ready: err_count += resp_err, saturating at all-ones; rr pointer = (grant+1) mod NREQ; next state IDLE.
  - resp_ready is ignored outside RESP.
- Latency: accept at cycle T; bits on T+1..T+DATA_W; resp_valid first high at T+DATA_W+1. Back-to-back throughput is one transfer per DATA_W+2 cycles with resp_ready tied high.
- req_valid deasserted during SHIFT/RESP has no effect. Requesters hold req_valid until they see req_ready.
- A requester that stays valid after being served loses priority to all others for the next arbitration (fairness).
- Pointer wrap: grant NREQ-1 sets the pointer to 0.

Decomposition:
- Package suba_ctrl_pkg:
  - state enum {IDLE, SHIFT, RESP}
  - DATA_W default constant
  - function for the rr pick, next-pointer computation
- One sub-module, suba_rr_arb:
  - combinational round-robin pick: req vector + pointer -> one-hot grant + index + any
  - parameterised by NREQ

Test Plan:
- Reset, then req_valid[0]=1, data 8'hA5 with real subA attached -> req_ready[0] pulse at T; suba_in_bit1 sequence 1,0,1,0,0,1,0,1; resp_valid at T+9; resp_data=8'h5A, resp_err=0, resp_id=0.
- All four requesters valid continuously, resp_ready=1 -> grants in order 0,1,2,3,0; each transfer takes 10 cycles.
- Fault model with suba_out_bit1 forced to 0, data 8'hFF -> resp_data=8'h00, resp_err=0. Then data 8'h0F -> resp_data=8'h00, resp_err=1, err_count=1.
- resp_ready held low 5 cycles in RESP -> resp_valid and resp_data stable, no new req_ready. Release -> IDLE next cycle, next grant follows.
- rst pulsed at 4th SHIFT cycle -> next cycle: busy=0, suba_in_bit1=0, resp_valid never asserts, pointer=0.
- Force 300 errored transfers with CNT_W=8 -> err_count stays at 8'hFF.
